// File: rtl/transformation_engine.sv
// Single-MAC dense matrix product FM_WM = FEATURE x WEIGHT, written column-major
// into the scratchpad consumed by the combination stage.
module transformation_engine #(
  parameter int FEATURE_ROWS       = 6,
  parameter int FEATURE_COLS       = 96,
  parameter int WEIGHT_COLS        = 3,
  parameter int DATA_WIDTH         = 5,
  parameter int DOT_PROD_WIDTH     = 16,
  parameter int FEATURE_ADDR_WIDTH = $clog2(FEATURE_ROWS*FEATURE_COLS),
  parameter int WEIGHT_ADDR_WIDTH  = $clog2(FEATURE_COLS*WEIGHT_COLS),
  parameter int ROW_WIDTH          = $clog2(FEATURE_ROWS),
  parameter int COL_WIDTH          = $clog2(WEIGHT_COLS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  output logic                          feature_read_enable,
  output logic [FEATURE_ADDR_WIDTH-1:0] feature_read_addr,
  input  logic [DATA_WIDTH-1:0]         feature_data,
  output logic                          weight_read_enable,
  output logic [WEIGHT_ADDR_WIDTH-1:0]  weight_read_addr,
  input  logic [DATA_WIDTH-1:0]         weight_data,
  output logic                          fm_wm_write_enable,
  output logic [ROW_WIDTH-1:0]          fm_wm_row,
  output logic [COL_WIDTH-1:0]          fm_wm_col,
  output logic [DOT_PROD_WIDTH-1:0]     fm_wm_data,
  output logic                          done_trans
);

  localparam int K_WIDTH = (FEATURE_COLS > 1) ? $clog2(FEATURE_COLS) : 1;

  localparam logic [K_WIDTH-1:0]            K_LAST = K_WIDTH'(FEATURE_COLS - 1);
  localparam logic [ROW_WIDTH-1:0]          R_LAST = ROW_WIDTH'(FEATURE_ROWS - 1);
  localparam logic [COL_WIDTH-1:0]          C_LAST = COL_WIDTH'(WEIGHT_COLS - 1);
  localparam logic [FEATURE_ADDR_WIDTH-1:0] FC_A   = FEATURE_ADDR_WIDTH'(FEATURE_COLS);
  localparam logic [WEIGHT_ADDR_WIDTH-1:0]  WC_A   = WEIGHT_ADDR_WIDTH'(WEIGHT_COLS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [K_WIDTH-1:0]        k_q, k_d;
  logic [ROW_WIDTH-1:0]      r_q, r_d;
  logic [COL_WIDTH-1:0]      c_q, c_d;
  logic [DOT_PROD_WIDTH-1:0] acc_q, acc_d;
  logic                      rd_valid_q, rd_valid_d;

  logic                      rd_en;
  logic                      wr_en;
  logic [2*DATA_WIDTH-1:0]   prod;

  assign prod = {{DATA_WIDTH{1'b0}}, feature_data} * {{DATA_WIDTH{1'b0}}, weight_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      r_q        <= '0;
      c_q        <= '0;
      acc_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      r_q        <= r_d;
      c_q        <= c_d;
      acc_q      <= acc_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    r_d        = r_q;
    c_d        = c_q;
    acc_d      = acc_q;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    done_trans = 1'b0;

    // Read data lags its strobe by one cycle, so the MAC keys off the registered strobe.
    if (rd_valid_q) begin
      acc_d = acc_q + DOT_PROD_WIDTH'(prod);
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          k_d     = '0;
          r_d     = '0;
          c_d     = '0;
          acc_d   = '0;
        end
      end
      S_READ: begin
        rd_en = 1'b1;
        if (k_q == K_LAST) begin
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DRAIN: begin
        state_d = S_WRITE;
      end
      S_WRITE: begin
        wr_en = 1'b1;
        acc_d = '0;
        k_d   = '0;
        if (r_q == R_LAST && c_q == C_LAST) begin
          state_d = S_DONE;
          r_d     = '0;
          c_d     = '0;
        end else if (r_q == R_LAST) begin
          state_d = S_READ;
          r_d     = '0;
          c_d     = c_q + 1'b1;
        end else begin
          state_d = S_READ;
          r_d     = r_q + 1'b1;
        end
      end
      S_DONE: begin
        done_trans = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    rd_valid_d = rd_en;

    feature_read_enable = rd_en;
    weight_read_enable  = rd_en;
    feature_read_addr   = '0;
    weight_read_addr    = '0;
    if (rd_en) begin
      feature_read_addr = FEATURE_ADDR_WIDTH'(r_q) * FC_A + FEATURE_ADDR_WIDTH'(k_q);
      weight_read_addr  = WEIGHT_ADDR_WIDTH'(k_q) * WC_A + WEIGHT_ADDR_WIDTH'(c_q);
    end

    fm_wm_write_enable = wr_en;
    fm_wm_row          = wr_en ? r_q : '0;
    fm_wm_col          = wr_en ? c_q : '0;
    fm_wm_data         = wr_en ? acc_q : '0;
  end

endmodule

// File: doc/transformation_engine.md
Name: transformation_engine

Overview:
- Upstream neighbour of the combination stage in the GCN datapath.
- Computes FM_WM = FEATURE (FEATURE_ROWS x FEATURE_COLS) x WEIGHT (FEATURE_COLS x WEIGHT_COLS), one output element at a time, using a single MAC.
- Reads the feature and weight memories through separate synchronous-read ports and writes each dot product into the FM_WM scratchpad that the combination stage reads.
- Raises done_trans, which drives the combination stage's start input.

Parameters:
- FEATURE_ROWS, 6, rows of feature matrix and of FM_WM.
- FEATURE_COLS, 96, inner dimension (feature columns = weight rows).
- WEIGHT_COLS, 3, columns of weight matrix and of FM_WM.
- DATA_WIDTH, 5, unsigned element width of feature and weight entries.
- DOT_PROD_WIDTH, 16, accumulator and FM_WM entry width.
- FEATURE_ADDR_WIDTH, $clog2(FEATURE_ROWS*FEATURE_COLS), feature memory address width.
- WEIGHT_ADDR_WIDTH, $clog2(FEATURE_COLS*WEIGHT_COLS), weight memory address width.
- ROW_WIDTH, $clog2(FEATURE_ROWS), FM_WM row index width.
- COL_WIDTH, $clog2(WEIGHT_COLS), FM_WM column index width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  begin computation (level-sampled in IDLE).
- feature_read_enable  out  1  feature memory read strobe.
- feature_read_addr  out  FEATURE_ADDR_WIDTH  row-major address, r*FEATURE_COLS+k.
- feature_data  in  DATA_WIDTH  feature entry, valid the cycle after its read strobe.
- weight_read_enable  out  1  weight memory read strobe.
- weight_read_addr  out  WEIGHT_ADDR_WIDTH  row-major address, k*WEIGHT_COLS+c.
- weight_data  in  DATA_WIDTH  weight entry, valid the cycle after its read strobe.
- fm_wm_write_enable  out  1  scratchpad write strobe.
- fm_wm_row  out  ROW_WIDTH  row r of the entry being written.
- fm_wm_col  out  COL_WIDTH  column c of the entry being written.
- fm_wm_data  out  DOT_PROD_WIDTH  dot product being written.
- done_trans  out  1  all FEATURE_ROWS*WEIGHT_COLS entries written.

Behaviour:
- Reset (async, any state, including mid-run): state=IDLE, all counters and the accumulator = 0, every output = 0. A partial element is never written.
- Counters:
  - k over 0..FEATURE_COLS-1.
  - r over 0..FEATURE_ROWS-1 (inner loop).
  - c over 0..WEIGHT_COLS-1 (outer loop).
  - Output order is column-major (c outer, r inner), matching the combination stage's consumption order.
- States:
  - IDLE: all strobes 0. If start is sampled 1, go to READ with k=r=c=0.
  - READ: both read_enables=1, addresses from the current r, k, c. k increments every cycle. After the k=FEATURE_COLS-1 cycle, go to DRAIN.
  - DRAIN: one cycle, read_enables=0. Accumulates the last product. Go to WRITE.
  - WRITE: one cycle. fm_wm_write_enable=1; fm_wm_row=r, fm_wm_col=c, fm_wm_data=accumulator. Clear the accumulator and k.
    - If r=FEATURE_ROWS-1 and c=WEIGHT_COLS-1, go to DONE.
    - Else if r=FEATURE_ROWS-1, set r=0, c=c+1, go to READ.
    - Else set r=r+1, go to READ.
  - DONE: done_trans=1, all strobes 0. Stays in DONE until reset.
- Datapath:
  - A read-valid flag registers read_enable, so the 1-cycle memory latency is matched.
  - When the flag is 1: acc <= acc + feature_data*weight_data.
  - The product is an unsigned 2*DATA_WIDTH value, zero-extended.
  - The sum wraps modulo 2^DOT_PROD_WIDTH; there is no saturation.
- Latency:
  - Each element takes FEATURE_COLS+2 cycles (READ x FEATURE_COLS, DRAIN, WRITE).
  - done_trans rises FEATURE_ROWS*WEIGHT_COLS*(FEATURE_COLS+2) cycles after the first READ cycle: 1764 cycles at the defaults.
  - The first READ cycle is the cycle after start is sampled.
- fm_wm_row, fm_wm_col and fm_wm_data hold 0 whenever fm_wm_write_enable=0.
- start is ignored outside IDLE, so a re-assertion mid-run or in DONE has no effect.
- Write-then-read: each entry is written exactly once, before done_trans. The combination stage reads only after done_trans, so no bypass is needed.

Test Plan:
- All features=1, all weights=1, start pulse -> 18 writes in order (r0c0, r1c0 .. r5c0, r0c1 .. r5c2), each data=96; done_trans high at cycle 1764 after the first READ cycle and held.
- Feature[r][k]=r+1, weight[k][c]=(k==c)?1:0 -> FM_WM[r][c]=r+1 for c<3 (only k=c contributes); write addresses verified each WRITE cycle.
- All entries=31 -> 96*961=92256 wraps to 92256-65536=26720 in every written entry.
- start held high for the whole run, plus an extra pulse at cycle 500 -> exactly one run of 18 writes, no restart, done_trans stays 1 until reset.
- Reset asserted at cycle 300 (mid-element) -> outputs 0 that same cycle asynchronously, no write of the partial element; a fresh start reproduces the golden 18 entries.
- Read-port check -> in READ, feature_read_addr = r*96+k and weight_read_addr = k*3+c for all k; read_enables=0 in DRAIN, WRITE, IDLE and DONE.
